// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and default widths for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Which port a read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_STARVE_LIMIT = 3;

endpackage
`default_nettype wire

// File: rtl/mem_arb_grant.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_grant
// Brief    : Combinational grant logic. Data beats fetch unless force_fetch
//            is raised by the starvation counter in the top level.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_grant (
    input  logic arb_en,       // low while the block is held in reset
    input  logic if_req,
    input  logic d_req,
    input  logic force_fetch,
    output logic grant_if,
    output logic grant_d
);

    // At most one grant per cycle; a forced fetch pre-empts the data port.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (arb_en) begin
            if (if_req && force_fetch) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-port memory between fetch and mem stages.
//            Combinational grant, one-cycle read return steered by an owner
//            register. Build option MEM_ARBITER_FAIRNESS_EN adds a fetch
//            starvation counter that forces a fetch grant after STARVE_LIMIT
//            consecutive denials.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    logic              grant_if;
    logic              grant_d;
    logic              force_fetch;
    owner_t            owner;
    owner_t            owner_nxt;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic [DATA_W-1:0] if_hold;
    logic [DATA_W-1:0] d_hold;

    mem_arb_grant u_grant (
        .arb_en      (Rst),
        .if_req      (if_req),
        .d_req       (d_req),
        .force_fetch (force_fetch),
        .grant_if    (grant_if),
        .grant_d     (grant_d)
    );

`ifdef MEM_ARBITER_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign force_fetch = (starve_cnt == CNT_W'(STARVE_LIMIT));

    // Count consecutive denied fetch cycles; any fetch grant or idle fetch clears.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            starve_cnt <= '0;
        end else if (!if_req || grant_if) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    // Drive the memory from the granted port; hold address/data when idle.
    always_comb begin
        mem_en    = grant_if | grant_d;
        mem_we    = grant_d & d_we;
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        if (grant_d) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
    end

    assign stall_if  = if_req & ~grant_if;
    assign stall_mem = d_req  & ~grant_d;

    // Remember who issued a read this cycle; writes and idle cycles clear it.
    always_comb begin
        owner_nxt = OWN_NONE;
        if (grant_d && !d_we) begin
            owner_nxt = OWN_DATA;
        end else if (grant_if) begin
            owner_nxt = OWN_FETCH;
        end
    end

    // Owner, held memory drive and last returned data per port.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            owner      <= OWN_NONE;
            addr_hold  <= '0;
            wdata_hold <= '0;
            if_hold    <= '0;
            d_hold     <= '0;
        end else begin
            owner      <= owner_nxt;
            addr_hold  <= mem_addr;
            wdata_hold <= mem_wdata;
            if (owner == OWN_FETCH) begin
                if_hold <= mem_rdata;
            end
            if (owner == OWN_DATA) begin
                d_hold <= mem_rdata;
            end
        end
    end

    // Return steering: live memory data in the return cycle, held value otherwise.
    always_comb begin
        if_valid = (owner == OWN_FETCH);
        d_valid  = (owner == OWN_DATA);
        if_rdata = if_valid ? mem_rdata : if_hold;
        d_rdata  = d_valid  ? mem_rdata : d_hold;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameters, one per line:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- STARVE_LIMIT, 3, consecutive fetch denials before a forced fetch grant.
REQ-002 The block SHALL expose ports, one per line:
- Clk  in  1  clock.
- Rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch-stage read request.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data.
- if_valid  out  1  fetch read data valid.
- stall_if  out  1  fetch request not granted this cycle.
- d_req  in  1  mem-stage access request.
- d_we  in  1  mem-stage write (1) / read (0).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data.
- d_valid  out  1  data read data valid.
- stall_mem  out  1  data request not granted this cycle.
- mem_en  out  1  shared single-port memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after a read issue.
REQ-003 Clk SHALL be the only clock; Rst SHALL be synchronous, active-low.

Function
REQ-004 Grant SHALL be combinational: at most one requester is granted per cycle, and the memory is driven in that same cycle.
REQ-005 Default priority SHALL be data over fetch; with both requests pending, the data request is granted.
REQ-006 A grant SHALL drive mem_en=1, with mem_addr, mem_we and mem_wdata taken from the granted port; a fetch grant SHALL drive mem_we=0.
REQ-007 With no grant: mem_en=0, mem_we=0; mem_addr and mem_wdata SHALL hold their last driven values.
REQ-008 stall_if SHALL equal if_req AND NOT fetch-grant; stall_mem SHALL equal d_req AND NOT data-grant.
REQ-009 A 2-bit registered owner (NONE, FETCH, DATA) SHALL record a read issued in cycle N.
REQ-010 In cycle N+1 the owner's valid SHALL pulse for exactly one cycle, with its rdata = mem_rdata; the other valid SHALL be 0.
REQ-011 Reads SHALL sustain back-to-back issue, one per cycle; a read issued in N and a read issued in N+1 SHALL return in N+1 and N+2 to their respective owners.
REQ-012 Writes SHALL complete in the grant cycle; they SHALL produce no valid pulse and SHALL set the owner to NONE.
REQ-013 Address and data SHALL be sampled only in the grant cycle; changes while stalled SHALL have no effect.
REQ-014 if_rdata and d_rdata SHALL hold their last returned value when not valid.

Reset
REQ-015 With Rst=0 at a clock edge: owner=NONE, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0, starvation counter=0.
REQ-016 A read in flight at reset SHALL be discarded; no valid pulse SHALL follow reset.
REQ-017 While Rst=0, mem_en and mem_we SHALL be 0 and no request SHALL be granted.

Configuration
REQ-018 Macro MEM_ARBITER_FAIRNESS_EN SHALL control anti-starvation.
- Defined: a counter SHALL increment on each cycle with if_req=1 and the fetch denied.
- Defined: when the counter equals STARVE_LIMIT, the fetch SHALL be granted that cycle regardless of d_req.
- Defined: the counter SHALL clear on any fetch grant or when if_req=0.
- Undefined: strict data priority applies; the counter logic SHALL NOT be present.

Structure
REQ-019 A shared package SHALL hold the owner enum (OWN_NONE, OWN_FETCH, OWN_DATA) and the default width constants.
REQ-020 Grant/priority logic SHALL be one sub-module, mem_arb_grant; the owner register, return steering and counter SHALL stay in the top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Fetch-only read: if_req=1, if_addr=0x0010, mem_rdata=0xA5A5 in the next cycle -> mem_en=1 in cycle N, if_valid=1 with if_rdata=0xA5A5 in N+1, stall_if=0.
- Collision: if_req=1 and d_req=1 (read 0x0200) in the same cycle -> mem_addr=0x0200, stall_if=1, stall_mem=0, d_valid=1 in N+1; fetch granted in N+1.
- Write: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234 in the grant cycle; no valid pulse in N+1.
- Back-to-back: data read in N, fetch read in N+1 -> d_valid in N+1, if_valid in N+2, each carrying the correct mem_rdata.
- Fairness (macro defined, STARVE_LIMIT=3): d_req and if_req held at 1 -> fetch denied 3 cycles, granted in the 4th with stall_mem=1; macro undefined -> fetch never granted.
- Reset mid-read: read issued in N, Rst=0 at the N+1 edge -> no valid pulse, all outputs at reset values.
